q_max_scanner: RTL and testbench

- Per-round learning stage that sits directly upstream of the node memory.
- On `start`, scans the stored neighbour table (ID, hops, Q-value), finds the maximum Q-value, and writes every neighbour holding that maximum into the memory's best-neighbour list.
- Then writes the summary words (`maxQ`, `bestNeighborsCount`) in one strobe.
- Feeds the memory's `mMaxQ`, `mBestNeighbors`, `mBestNeighborsHop` and `mbestNeighborsCount` inputs.

---
 rtl/eer_rl_pkg.sv | 26 ++
 rtl/q_max_scanner.sv | 129 ++++++++++++
 tb/tb_q_max_scanner.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/eer_rl_pkg.sv
// Shared constants and types for the EER reinforcement-learning datapath:
// table geometry, word width and the Q-max scanner state encoding.
package eer_rl_pkg;

   localparam int WORD_WIDTH    = 16;
   localparam int MAX_NEIGHBORS = 16;
   localparam int ADDR_W        = 4;
   // One extra bit so a count/index can hold MAX_NEIGHBORS itself.
   localparam int CNT_W         = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN_MAX,
      SCAN_SEL,
      SUMMARY
   } qscan_state_t;

   // Limit a requested neighbour count to the physical table depth.
   function automatic logic [CNT_W-1:0] clamp_count(input logic [WORD_WIDTH-1:0] n);
      if (n > WORD_WIDTH'(MAX_NEIGHBORS)) begin
         return CNT_W'(MAX_NEIGHBORS);
      end
      return n[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/q_max_scanner.sv
// Per-round Q-max scanner: two passes over the neighbour table. Pass one finds
// the largest Q-value, pass two writes every neighbour holding it into the
// best-neighbour list, then a single summary strobe publishes maxQ and count.
module q_max_scanner
   import eer_rl_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] neighborCount,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [WORD_WIDTH-1:0] rd_neighborID,
   input  logic [WORD_WIDTH-1:0] rd_neighborHops,
   input  logic [WORD_WIDTH-1:0] rd_neighborQValue,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [WORD_WIDTH-1:0] mBestNeighbors,
   output logic [WORD_WIDTH-1:0] mBestNeighborsHop,
   output logic                  sum_wr,
   output logic [WORD_WIDTH-1:0] mMaxQ,
   output logic [WORD_WIDTH-1:0] mbestNeighborsCount,
   output logic                  busy,
   output logic                  done
);

   qscan_state_t          state_q, state_d;
   logic [CNT_W-1:0]      n_q, n_d;        // latched, clamped entry count
   logic [CNT_W-1:0]      idx_q, idx_d;    // read index within the current pass
   logic [CNT_W-1:0]      best_q, best_d;  // entries written to the best list
   logic [WORD_WIDTH-1:0] max_q, max_d;
   logic                  vld_q, vld_d;    // rd_* carries a datum requested last cycle
   logic                  scanning;
   logic                  issue;
   logic                  hit;

   // Read-issue and best-match decode shared by the FSM and the output muxes.
   always_comb begin
      scanning = (state_q == SCAN_MAX) || (state_q == SCAN_SEL);
      issue    = scanning && (idx_q < n_q);
      hit      = (state_q == SCAN_SEL) && vld_q && (rd_neighborQValue == max_q);
   end

   // Next-state, datapath updates and per-cycle strobes.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d           = state_q;
      n_d               = n_q;
      idx_d             = idx_q;
      best_d            = best_q;
      max_d             = max_q;
      vld_d             = issue;
      rd_addr           = issue ? idx_q[ADDR_W-1:0] : '0;
      wr_en             = hit;
      wr_addr           = hit ? best_q[ADDR_W-1:0] : '0;
      mBestNeighbors    = hit ? rd_neighborID : '0;
      mBestNeighborsHop = hit ? rd_neighborHops : '0;
      sum_wr            = 1'b0;
      done              = 1'b0;
      busy              = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (start) begin
               n_d     = clamp_count(neighborCount);
               max_d   = '0;
               best_d  = '0;
               idx_d   = '0;
               state_d = (clamp_count(neighborCount) == '0) ? SUMMARY : SCAN_MAX;
            end
         end
         SCAN_MAX: begin
            if (vld_q && (rd_neighborQValue > max_q)) begin
               max_d = rd_neighborQValue;
            end
            if (idx_q == n_q) begin
               idx_d   = '0;
               state_d = SCAN_SEL;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         SCAN_SEL: begin
            if (hit) begin
               best_d = best_q + 1'b1;
            end
            if (idx_q == n_q) begin
               idx_d   = '0;
               state_d = SUMMARY;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         SUMMARY: begin
            sum_wr  = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         best_q  <= '0;
         max_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         best_q  <= best_d;
         max_q   <= max_d;
         vld_q   <= vld_d;
      end
   end

   // Summary words follow the working registers; they are cleared on an
   // accepted start and hold from done until the next one.
   assign mMaxQ               = max_q;
   assign mbestNeighborsCount = {{(WORD_WIDTH-CNT_W){1'b0}}, best_q};

endmodule

// File: tb/tb_q_max_scanner.sv
// Scoreboard bench for q_max_scanner: stimulus pushes hand-computed best-list
// writes and summary words; a negedge monitor pops and compares them.
module tb_q_max_scanner;
   import eer_rl_pkg::*;

   logic                  clock;
   logic                  reset;
   logic                  start;
   logic [WORD_WIDTH-1:0] neighborCount;
   logic [ADDR_W-1:0]     rd_addr;
   logic [WORD_WIDTH-1:0] rd_neighborID;
   logic [WORD_WIDTH-1:0] rd_neighborHops;
   logic [WORD_WIDTH-1:0] rd_neighborQValue;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [WORD_WIDTH-1:0] mBestNeighbors;
   logic [WORD_WIDTH-1:0] mBestNeighborsHop;
   logic                  sum_wr;
   logic [WORD_WIDTH-1:0] mMaxQ;
   logic [WORD_WIDTH-1:0] mbestNeighborsCount;
   logic                  busy;
   logic                  done;

   q_max_scanner dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .neighborCount       (neighborCount),
      .rd_addr             (rd_addr),
      .rd_neighborID       (rd_neighborID),
      .rd_neighborHops     (rd_neighborHops),
      .rd_neighborQValue   (rd_neighborQValue),
      .wr_en               (wr_en),
      .wr_addr             (wr_addr),
      .mBestNeighbors      (mBestNeighbors),
      .mBestNeighborsHop   (mBestNeighborsHop),
      .sum_wr              (sum_wr),
      .mMaxQ               (mMaxQ),
      .mbestNeighborsCount (mbestNeighborsCount),
      .busy                (busy),
      .done                (done)
   );

   typedef struct packed {
      logic [ADDR_W-1:0]     addr;
      logic [WORD_WIDTH-1:0] id;
      logic [WORD_WIDTH-1:0] hop;
   } wr_exp_t;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] maxq;
      logic [WORD_WIDTH-1:0] cnt;
      logic [31:0]           cyc;
   } sum_exp_t;

   wr_exp_t  exp_wr[$];
   sum_exp_t exp_sum[$];

   logic [WORD_WIDTH-1:0] tbl_id  [MAX_NEIGHBORS];
   logic [WORD_WIDTH-1:0] tbl_hop [MAX_NEIGHBORS];
   logic [WORD_WIDTH-1:0] tbl_q   [MAX_NEIGHBORS];

   int n_vec;
   int n_err;
   int cyc;
   int start_cyc;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Neighbour table: synchronous read, data one cycle after the address.
   always @(posedge clock) begin
      rd_neighborID     <= tbl_id[rd_addr];
      rd_neighborHops   <= tbl_hop[rd_addr];
      rd_neighborQValue <= tbl_q[rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every DUT strobe must match the oldest outstanding expectation.
   always @(negedge clock) begin
      wr_exp_t  ew;
      sum_exp_t es;
      if (wr_en) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
         end else begin
            ew = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(ew.addr));
            check("wr_id", 32'(mBestNeighbors), 32'(ew.id));
            check("wr_hop", 32'(mBestNeighborsHop), 32'(ew.hop));
         end
      end
      if (sum_wr) begin
         if (exp_sum.size() == 0) begin
            check("unexpected_sum_wr", 32'(mMaxQ), 32'hFFFF_FFFF);
         end else begin
            es = exp_sum.pop_front();
            check("sum_maxq", 32'(mMaxQ), 32'(es.maxq));
            check("sum_count", 32'(mbestNeighborsCount), 32'(es.cnt));
            check("done_cycle", 32'(cyc - start_cyc), es.cyc);
            check("done_with_sum", 32'(done), 32'd1);
         end
      end
   end

   task automatic push_wr(input int a, input int id, input int hop);
      exp_wr.push_back('{addr: ADDR_W'(a), id: WORD_WIDTH'(id), hop: WORD_WIDTH'(hop)});
   endtask

   task automatic load(input int i, input int id, input int hop, input int q);
      tbl_id[i]  = WORD_WIDTH'(id);
      tbl_hop[i] = WORD_WIDTH'(hop);
      tbl_q[i]   = WORD_WIDTH'(q);
   endtask

   // Start one scan, optionally re-pulse start at a given cycle, wait for done.
   task automatic run_scan(input int n, input int emax, input int ecnt, input int ecyc,
                           input int inject_at);
      int waited;
      exp_sum.push_back('{maxq: WORD_WIDTH'(emax), cnt: WORD_WIDTH'(ecnt), cyc: 32'(ecyc)});
      @(negedge clock);
      neighborCount = WORD_WIDTH'(n);
      start         = 1'b1;
      start_cyc     = cyc;
      @(negedge clock);
      start         = 1'b0;
      neighborCount = '0;
      waited        = 1;
      while (!done && waited < 200) begin
         if (waited == inject_at) begin
            start         = 1'b1;
            neighborCount = 16'd3;
         end
         @(negedge clock);
         start = 1'b0;
         waited++;
      end
      if (!done) begin
         check("done_timeout", 32'(waited), 32'(ecyc));
      end else begin
         @(negedge clock);
         check("busy_after_done", 32'(busy), 32'd0);
         check("hold_maxq", 32'(mMaxQ), 32'(emax));
         check("hold_count", 32'(mbestNeighborsCount), 32'(ecnt));
      end
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      cyc           = 0;
      start_cyc     = 0;
      reset         = 1'b1;
      start         = 1'b0;
      neighborCount = '0;
      for (int i = 0; i < MAX_NEIGHBORS; i++) load(i, 0, 0, 0);

      repeat (2) @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_sum_wr", 32'(sum_wr), 32'd0);
      check("rst_maxq", 32'(mMaxQ), 32'd0);
      check("rst_count", 32'(mbestNeighborsCount), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      reset = 1'b0;

      // Two-way tie on 0x0040.
      load(0, 5, 1, 16'h0010); load(1, 6, 2, 16'h0040);
      load(2, 7, 3, 16'h0020); load(3, 8, 4, 16'h0040);
      push_wr(0, 6, 2); push_wr(1, 8, 4);
      run_scan(4, 16'h0040, 2, 11, 0);

      // Empty table: straight to SUMMARY.
      run_scan(0, 0, 0, 1, 0);

      // All-zero Q: every entry is a tie.
      load(0, 9, 7, 0); load(1, 10, 8, 0); load(2, 11, 9, 0);
      push_wr(0, 9, 7); push_wr(1, 10, 8); push_wr(2, 11, 9);
      run_scan(3, 0, 3, 9, 0);

      // Clamp 20 -> 16; unsigned compare (0xFFFF beats 0x8000).
      for (int i = 0; i < MAX_NEIGHBORS; i++) load(i, 100 + i, i, i);
      tbl_q[3]  = 16'h8000;
      tbl_q[15] = 16'hFFFF;
      push_wr(0, 115, 15);
      run_scan(20, 16'hFFFF, 1, 35, 0);

      // Start re-pulsed during SCAN_SEL is ignored.
      load(0, 5, 1, 16'h0010); load(1, 6, 2, 16'h0040);
      load(2, 7, 3, 16'h0020); load(3, 8, 4, 16'h0040);
      push_wr(0, 6, 2); push_wr(1, 8, 4);
      run_scan(4, 16'h0040, 2, 11, 6);

      // Reset during SCAN_MAX of an N=8 scan.
      load(0, 20, 30, 3); load(1, 21, 31, 9); load(2, 22, 32, 1); load(3, 23, 33, 9);
      load(4, 24, 34, 9); load(5, 25, 35, 2); load(6, 26, 36, 0); load(7, 27, 37, 8);
      @(negedge clock);
      neighborCount = 16'd8;
      start         = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      check("pre_abort_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_sum_wr", 32'(sum_wr), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_maxq", 32'(mMaxQ), 32'd0);
      check("abort_count", 32'(mbestNeighborsCount), 32'd0);
      check("abort_rd_addr", 32'(rd_addr), 32'd0);
      reset = 1'b0;
      repeat (25) @(negedge clock);
      check("idle_after_abort", 32'(busy), 32'd0);
      push_wr(0, 21, 31); push_wr(1, 23, 33); push_wr(2, 24, 34);
      run_scan(8, 9, 3, 19, 0);

      repeat (3) @(negedge clock);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check("sum_queue_drained", 32'(exp_sum.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
